// File: rtl/sparc_exu_bitscan_if.sv
// Valid/ready word-in, index-out bus for sparc_exu_bitscan.
// The slave modport is the scanner; the master modport is its producer/consumer side.
interface sparc_exu_bitscan_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned IDXW  = 5
);
    logic             in_vld;
    logic [WIDTH-1:0] in_data;
    logic             in_rdy;
    logic             out_vld;
    logic [IDXW-1:0]  out_idx;
    logic             out_last;
    logic             out_zero;
    logic             out_rdy;

    modport slave (
        input  in_vld, in_data, out_rdy,
        output in_rdy, out_vld, out_idx, out_last, out_zero
    );

    modport master (
        output in_vld, in_data, out_rdy,
        input  in_rdy, out_vld, out_idx, out_last, out_zero
    );
endinterface

// File: rtl/sparc_exu_bitscan.sv
// Expands a captured word into one beat per set bit, lowest index first; a zero word gives one flagged beat.
// Optional SPARC_EXU_BITSCAN_COUNT_EN adds out_cnt, the population count latched at capture.
module sparc_exu_bitscan #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned IDXW  = 5
) (
    input  logic                 rclk,
    input  logic                 arst_l,
    sparc_exu_bitscan_if.slave   bus,
`ifdef SPARC_EXU_BITSCAN_COUNT_EN
    output logic [IDXW:0]        out_cnt,
`endif
    output logic                 busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ZERO = 2'd1,
        SCAN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] residue_q, residue_d;
    logic [IDXW-1:0]  low_idx;
    logic             one_left;

    // Lowest set bit of residue: scan downward so the lowest position wins.
    always_comb begin
        low_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (residue_q[i]) low_idx = IDXW'(i);
        end
    end

    assign one_left = ((residue_q & (residue_q - WIDTH'(1))) == '0);

    always_comb begin
        state_d      = state_q;
        residue_d    = residue_q;
        bus.in_rdy   = 1'b0;
        bus.out_vld  = 1'b0;
        bus.out_idx  = '0;
        bus.out_last = 1'b0;
        bus.out_zero = 1'b0;
        busy         = 1'b1;
        unique case (state_q)
            IDLE: begin
                bus.in_rdy = 1'b1;
                busy       = 1'b0;
                if (bus.in_vld) begin
                    residue_d = bus.in_data;
                    state_d   = (bus.in_data == '0) ? ZERO : SCAN;
                end
            end
            ZERO: begin
                bus.out_vld  = 1'b1;
                bus.out_zero = 1'b1;
                bus.out_last = 1'b1;
                if (bus.out_rdy) state_d = IDLE;
            end
            SCAN: begin
                bus.out_vld  = 1'b1;
                bus.out_idx  = low_idx;
                bus.out_last = one_left;
                if (bus.out_rdy) begin
                    residue_d = residue_q & (residue_q - WIDTH'(1));
                    if (one_left) begin
                        residue_d = '0;
                        state_d   = IDLE;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                residue_d = '0;
            end
        endcase
    end

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            state_q   <= IDLE;
            residue_q <= '0;
        end else begin
            state_q   <= state_d;
            residue_q <= residue_d;
        end
    end

`ifdef SPARC_EXU_BITSCAN_COUNT_EN
    logic [IDXW:0] cnt_q, cnt_d;
    logic [IDXW:0] pop_c;

    always_comb begin
        pop_c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop_c = pop_c + (IDXW+1)'(bus.in_data[i]);
        end
        cnt_d = cnt_q;
        if (state_q == IDLE && bus.in_vld) cnt_d = pop_c;
    end

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign out_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_sparc_exu_bitscan.sv
// Directed bench for sparc_exu_bitscan; define SPARC_EXU_BITSCAN_COUNT_EN to cover out_cnt.
module tb_sparc_exu_bitscan;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned IDXW  = 5;

    logic rclk;
    logic arst_l;
    logic busy;
`ifdef SPARC_EXU_BITSCAN_COUNT_EN
    logic [IDXW:0] out_cnt;
`endif

    int n_checks;
    int n_errors;

    sparc_exu_bitscan_if #(.WIDTH(WIDTH), .IDXW(IDXW)) bus ();

    sparc_exu_bitscan #(.WIDTH(WIDTH), .IDXW(IDXW)) dut (
        .rclk   (rclk),
        .arst_l (arst_l),
        .bus    (bus.slave),
`ifdef SPARC_EXU_BITSCAN_COUNT_EN
        .out_cnt(out_cnt),
`endif
        .busy   (busy)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (observed running, expected done)");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic vld, input logic [IDXW-1:0] idx,
                            input logic last, input logic zero);
        chk({tag, ".vld"},  32'(bus.out_vld),  32'(vld));
        chk({tag, ".idx"},  32'(bus.out_idx),  32'(idx));
        chk({tag, ".last"}, 32'(bus.out_last), 32'(last));
        chk({tag, ".zero"}, 32'(bus.out_zero), 32'(zero));
    endtask

    task automatic chk_idle(input string tag);
        chk_beat(tag, 1'b0, '0, 1'b0, 1'b0);
        chk({tag, ".in_rdy"}, 32'(bus.in_rdy), 32'd1);
        chk({tag, ".busy"},   32'(busy),       32'd0);
    endtask

    // Presents a word for one cycle from a negedge; returns on the negedge after capture.
    task automatic send(input logic [WIDTH-1:0] word);
        bus.in_vld  = 1'b1;
        bus.in_data = word;
        @(negedge rclk);
        bus.in_vld  = 1'b0;
        bus.in_data = '0;
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        arst_l      = 1'b0;
        bus.in_vld  = 1'b0;
        bus.in_data = '0;
        bus.out_rdy = 1'b1;
        repeat (2) @(negedge rclk);
        chk_idle("reset");
`ifdef SPARC_EXU_BITSCAN_COUNT_EN
        chk("reset.cnt", 32'(out_cnt), 32'd0);
`endif
        arst_l = 1'b1;
        @(negedge rclk);
        chk_idle("post_reset");

        // Zero word: one flagged beat, then ready again.
        send(32'h0000_0000);
        chk_beat("zero", 1'b1, 5'd0, 1'b1, 1'b1);
        chk("zero.in_rdy", 32'(bus.in_rdy), 32'd0);
        chk("zero.busy",   32'(busy),       32'd1);
        @(negedge rclk);
        chk_idle("zero.done");

        // Extremes of the index range.
        send(32'h8000_0001);
        chk_beat("ends.b0", 1'b1, 5'd0, 1'b0, 1'b0);
        @(negedge rclk);
        chk_beat("ends.b1", 1'b1, 5'd31, 1'b1, 1'b0);
        chk("ends.busy", 32'(busy), 32'd1);
        @(negedge rclk);
        chk_idle("ends.done");

        // All ones: 32 beats, in_vld pulses during the scan are ignored.
        send(32'hFFFF_FFFF);
        for (int i = 0; i < 32; i++) begin
            chk_beat("ones", 1'b1, IDXW'(i), (i == 31), 1'b0);
            chk("ones.in_rdy", 32'(bus.in_rdy), 32'd0);
            if (i == 5) begin
                bus.in_vld  = 1'b1;
                bus.in_data = 32'h0000_1234;
            end else if (i == 7) begin
                bus.in_vld  = 1'b0;
                bus.in_data = '0;
            end
            @(negedge rclk);
        end
        chk_idle("ones.done");

        // Backpressure holds the first beat.
        bus.out_rdy = 1'b0;
        send(32'h0000_0014);
        for (int i = 0; i < 3; i++) begin
            chk_beat("bp.hold", 1'b1, 5'd2, 1'b0, 1'b0);
            @(negedge rclk);
        end
        chk_beat("bp.hold3", 1'b1, 5'd2, 1'b0, 1'b0);
        bus.out_rdy = 1'b1;
        @(negedge rclk);
        chk_beat("bp.b1", 1'b1, 5'd4, 1'b1, 1'b0);
        @(negedge rclk);
        chk_idle("bp.done");

        // Reset in mid-scan discards the rest of the word.
        send(32'h0000_00F0);
        chk_beat("rst.b0", 1'b1, 5'd4, 1'b0, 1'b0);
        @(negedge rclk);
        chk_beat("rst.b1", 1'b1, 5'd5, 1'b0, 1'b0);
        arst_l = 1'b0;
        #1;
        chk_beat("rst.async", 1'b0, 5'd0, 1'b0, 1'b0);
        @(negedge rclk);
        arst_l = 1'b1;
        @(negedge rclk);
        chk_idle("rst.after");
        @(negedge rclk);
        chk_idle("rst.quiet");
        send(32'h0000_0002);
        chk_beat("rst.new", 1'b1, 5'd1, 1'b1, 1'b0);
        @(negedge rclk);
        chk_idle("rst.new_done");

`ifdef SPARC_EXU_BITSCAN_COUNT_EN
        // Population count latched at capture and held.
        send(32'h0000_F00F);
        for (int i = 0; i < 8; i++) begin
            chk("cnt.scan", 32'(out_cnt), 32'd8);
            @(negedge rclk);
        end
        chk_idle("cnt.done");
        chk("cnt.hold", 32'(out_cnt), 32'd8);
        send(32'h0000_0000);
        chk("cnt.zero", 32'(out_cnt), 32'd0);
        @(negedge rclk);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
